// File: rtl/div_mem_sequencer_if.sv
// Purpose: bundles the run-control and scratch-memory strobe signals of div_mem_sequencer.
// Latency: none, wires only.
// Backpressure: none; the divider handshake is a single div_done pulse per read.
interface div_mem_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              div_done;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_en;
    logic [ADDR_W-1:0] wt_addr;
    logic              wt_en;
    logic              busy;
    logic              done;
    logic              err;

    // Sequencer side: consumes start/div_done, drives every strobe and address.
    modport master (
        input  start,
        input  div_done,
        output rd_addr1,
        output rd_addr2,
        output rd_en,
        output wt_addr,
        output wt_en,
        output busy,
        output done,
        output err
    );

    // Environment side: memory, divider and run controller.
    modport slave (
        output start,
        output div_done,
        input  rd_addr1,
        input  rd_addr2,
        input  rd_en,
        input  wt_addr,
        input  wt_en,
        input  busy,
        input  done,
        input  err
    );
endinterface

// File: rtl/div_mem_sequencer.sv
// Purpose: runs NUM_OPS divisions: read operands, wait for divider, write quotient, pulse done.
// Latency: rd_en one cycle after start, wt_en one cycle after div_done, done one cycle after last wt_en.
// Backpressure: waits in WAIT_DIV for div_done; DIV_MEM_SEQ_WATCHDOG_EN adds a TIMEOUT_CYC abort with err.
module div_mem_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int NUM_OPS     = 32,
    parameter int RD_BASE     = 64,
    parameter int WT_BASE     = 128,
    parameter int PAIR_MODE   = 1,
    parameter int DENOM_ADDR  = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    div_mem_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_RD = 3'd1,
        WAIT_DIV = 3'd2,
        WRITE    = 3'd3,
        FIN      = 3'd4
    } state_t;

    // Address arithmetic is done at ADDR_W bits so it wraps modulo 2^ADDR_W.
    localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RD_BASE);
    localparam logic [ADDR_W-1:0] WT_BASE_A = ADDR_W'(WT_BASE);
    localparam logic [ADDR_W-1:0] DENOM_A   = ADDR_W'(DENOM_ADDR);
    localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(NUM_OPS - 1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

    if (NUM_OPS < 1) begin : g_bad_num_ops
        $error("div_mem_sequencer: NUM_OPS must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("div_mem_sequencer: TIMEOUT_CYC must be at least 1");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
    logic [ADDR_W-1:0] rd_addr2_q, rd_addr2_d;
    logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              wt_en_q, wt_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef DIV_MEM_SEQ_WATCHDOG_EN
    // Counter only has to reach TIMEOUT_CYC-1: that value marks the last WAIT_DIV cycle.
    localparam int             WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    // State, op index and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
            wt_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            wt_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DIV_MEM_SEQ_WATCHDOG_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            rd_addr1_q <= rd_addr1_d;
            rd_addr2_q <= rd_addr2_d;
            wt_addr_q  <= wt_addr_d;
            rd_en_q    <= rd_en_d;
            wt_en_q    <= wt_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DIV_MEM_SEQ_WATCHDOG_EN
            wd_q       <= wd_d;
            err_q      <= err_d;
`endif
        end
    end

    // Next state and op index; start and div_done only matter in IDLE and WAIT_DIV.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
`ifdef DIV_MEM_SEQ_WATCHDOG_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE_RD;
                    k_d     = '0;
`ifdef DIV_MEM_SEQ_WATCHDOG_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ISSUE_RD: begin
                state_d = WAIT_DIV;
`ifdef DIV_MEM_SEQ_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            WAIT_DIV: begin
                if (bus.div_done) begin
                    state_d = WRITE;
                end
`ifdef DIV_MEM_SEQ_WATCHDOG_EN
                else if (wd_q == WD_LIM) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
`endif
            end
            WRITE: begin
                if (k_q == LAST_K) begin
                    state_d = FIN;
                end else begin
                    state_d = ISSUE_RD;
                    k_d     = k_q + ONE_A;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so every output comes straight from a flop.
    always_comb begin
        rd_en_d    = 1'b0;
        wt_en_d    = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_d != IDLE);
        rd_addr1_d = rd_addr1_q;
        rd_addr2_d = rd_addr2_q;
        wt_addr_d  = wt_addr_q;
        case (state_d)
            ISSUE_RD: begin
                rd_en_d = 1'b1;
                if (PAIR_MODE != 0) begin
                    rd_addr1_d = RD_BASE_A + k_d + k_d;
                    rd_addr2_d = RD_BASE_A + k_d + k_d + ONE_A;
                end else begin
                    rd_addr1_d = RD_BASE_A + k_d;
                    rd_addr2_d = DENOM_A;
                end
            end
            WRITE: begin
                wt_en_d   = 1'b1;
                wt_addr_d = WT_BASE_A + k_d;
            end
            FIN: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.rd_addr1 = rd_addr1_q;
    assign bus.rd_addr2 = rd_addr2_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.wt_addr  = wt_addr_q;
    assign bus.wt_en    = wt_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
`ifdef DIV_MEM_SEQ_WATCHDOG_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif

endmodule

// File: doc/div_mem_sequencer.md
DIV_MEM_SEQUENCER -- requirements
Module: div_mem_sequencer

Interface
REQ-001 Parameter ADDR_W, 16, width of all scratch-memory addresses.
REQ-002 Parameter NUM_OPS, 32, number of divisions per run (1..2^ADDR_W-1).
REQ-003 Parameter RD_BASE, 64, first read address.
REQ-004 Parameter WT_BASE, 128, first write address.
REQ-005 Parameter PAIR_MODE, 1, 1 = operand pair read from consecutive addresses; 0 = one operand per op plus a fixed denominator address.
REQ-006 Parameter DENOM_ADDR, 0, rd_addr2 value when PAIR_MODE=0.
REQ-007 Parameter TIMEOUT_CYC, 255, watchdog limit in cycles (used only with the macro in REQ-030).
REQ-008 clk  input  1  clock, rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 start  input  1  run request, sampled only in IDLE.
REQ-011 div_done  input  1  divider result valid, sampled only in WAIT_DIV.
REQ-012 rd_addr1, rd_addr2  output  ADDR_W  scratch read addresses.
REQ-013 rd_en  output  1  read strobe; also launches the divider.
REQ-014 wt_addr  output  ADDR_W  scratch write address.
REQ-015 wt_en  output  1  write strobe for the quotient.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle end-of-run pulse.
REQ-018 err  output  1  watchdog error flag.

Function
REQ-019 All outputs SHALL be registered, with states IDLE, ISSUE_RD, WAIT_DIV, WRITE, and FIN, and an op index k counting 0..NUM_OPS-1.
REQ-020 IDLE SHALL go to ISSUE_RD with k=0 when start=1; start in any other state SHALL be ignored.
REQ-021 ISSUE_RD SHALL last one cycle with rd_en=1, then go to WAIT_DIV.
REQ-022 When PAIR_MODE=1, ISSUE_RD SHALL drive rd_addr1=RD_BASE+2k and rd_addr2=RD_BASE+2k+1.
REQ-023 When PAIR_MODE=0, ISSUE_RD SHALL drive rd_addr1=RD_BASE+k and rd_addr2=DENOM_ADDR.
REQ-024 WAIT_DIV SHALL hold rd_en=0 and SHALL go to WRITE on div_done=1; div_done in any other state, including the ISSUE_RD cycle, SHALL be ignored.
REQ-025 WRITE SHALL last one cycle with wt_en=1 and wt_addr=WT_BASE+k, then go to FIN if k=NUM_OPS-1, otherwise to ISSUE_RD with k+1.
REQ-026 FIN SHALL last one cycle with done=1, then go to IDLE.
REQ-027 Latency: rd_en SHALL be high in the cycle after the edge that samples start; wt_en SHALL be high in the cycle after the edge that samples div_done; done SHALL be high in the cycle after the last wt_en.
REQ-028 Address arithmetic SHALL be modulo 2^ADDR_W, wrapping silently with no flag.
REQ-029 Outside their strobe cycles, address outputs SHALL hold their last value; rd_en, wt_en and done SHALL be 0.

Configuration
REQ-030 With DIV_MEM_SEQ_WATCHDOG_EN defined, a counter SHALL clear on entry to WAIT_DIV; if TIMEOUT_CYC cycles elapse without div_done, the block SHALL go to FIN with no write and set err=1; err SHALL clear on the next accepted start or on reset.
REQ-031 Without DIV_MEM_SEQ_WATCHDOG_EN, no watchdog logic SHALL exist, err SHALL be tied to 0, and WAIT_DIV SHALL wait indefinitely.

Reset
REQ-032 Reset SHALL force IDLE, k=0, all address outputs to 0, rd_en=wt_en=busy=done=err=0, and the watchdog count to 0.
REQ-033 Reset mid-run SHALL abort the run with no further strobes, and no done pulse SHALL be emitted.

Verification
REQ-034 Defaults, start, div_done 3 cycles after each rd_en -> 32 reads at 64/65, 66/67 ... 126/127; 32 writes at 128..159; a single done pulse; err=0.
REQ-035 PAIR_MODE=0, DENOM_ADDR=10, NUM_OPS=4 -> rd_addr1 64..67, rd_addr2=10 on every read, writes 128..131.
REQ-036 div_done asserted in the ISSUE_RD cycle and start asserted while busy -> both ignored; the sequence equals scenario REQ-034.
REQ-037 ADDR_W=8, RD_BASE=254, NUM_OPS=2, PAIR_MODE=1 -> reads at 254/255 then 0/1.
REQ-038 Reset after the 5th write -> all outputs 0 next cycle, no done; a fresh start runs again from k=0.
REQ-039 Macro defined, TIMEOUT_CYC=8, div_done withheld -> done and err=1 after 8 WAIT_DIV cycles with no wt_en; the next start clears err.
